// File: rtl/mm_register_arbiter_pkg.sv
// Shared types and constants for the Avalon-MM register-port arbiter.
// Widths default to the register-bank geometry used by the MAC-address block.
package mm_register_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } mm_arb_state_t;

    localparam int MM_ARB_MAX_PEND = 4;
    localparam int ADDRESS_SIZE    = 8;
    localparam int REG_SIZE        = 32;

    localparam logic [ADDRESS_SIZE-1:0] SOURCE_MAC_ADDR_2 = 8'h04;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mm_register_arbiter_id_fifo.sv
// In-order FIFO of master IDs for reads still waiting on readdatavalid.
// Push and pop in the same cycle are honoured even when the FIFO is full.
module mm_arb_id_fifo
    import mm_register_arbiter_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = clog2_min1(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wr_en_s, rd_en_s;

    assign full    = (cnt_q == CNT_MAX);
    assign empty   = (cnt_q == {CW{1'b0}});
    assign dout    = mem_q[rptr_q];
    assign rd_en_s = pop & ~empty;
    assign wr_en_s = push & (~full | rd_en_s);

    // Next pointer, count and storage contents.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (wr_en_s) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (rd_en_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wptr_q <= {PW{1'b0}};
            rptr_q <= {PW{1'b0}};
            cnt_q  <= {CW{1'b0}};
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/mm_register_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM register slave among NUM_M masters,
// routing each read response back to its issuer through an in-order ID FIFO.
module mm_register_arbiter
    import mm_register_arbiter_pkg::*;
#(
    parameter int NUM_M    = 2,
    parameter int ADDR_W   = ADDRESS_SIZE,
    parameter int DATA_W   = REG_SIZE,
    parameter int MAX_PEND = MM_ARB_MAX_PEND
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_M*ADDR_W-1:0] m_address,
    input  logic [NUM_M*DATA_W-1:0] m_writedata,
    input  logic [NUM_M-1:0]        m_write,
    input  logic [NUM_M-1:0]        m_read,
    output logic [NUM_M-1:0]        m_waitrequest,
    output logic [NUM_M*DATA_W-1:0] m_readdata,
    output logic [NUM_M-1:0]        m_readdatavalid,
    output logic [ADDR_W-1:0]       s_address,
    output logic [DATA_W-1:0]       s_writedata,
    output logic                    s_write,
    output logic                    s_read,
    input  logic                    s_waitrequest,
    input  logic [DATA_W-1:0]       s_readdata,
    input  logic                    s_readdatavalid,
    output logic                    orphan_err
);
    localparam int GW = clog2_min1(NUM_M);

    mm_arb_state_t           state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [GW-1:0]           last_grant_q, last_grant_d;
    logic                    orphan_q, orphan_d;
    logic [NUM_M-1:0]        rdv_q, rdv_d;
    logic [NUM_M*DATA_W-1:0] rdata_q, rdata_d;

    logic [NUM_M-1:0]  req_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sel_write_s, sel_read_s, fwd_read_s;
    logic              accept_s, fifo_push_s, fifo_pop_s;
    logic              fifo_full_s, fifo_empty_s;
    logic [GW-1:0]     head_id_s;

    // First requester strictly after the previous winner, wrapping.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_M-1:0] r, input logic [GW-1:0] last);
        logic [GW-1:0] pick;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_M; k++) begin
            idx = (int'(last) + k) % NUM_M;
            if (!found && r[idx]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    assign req_s       = m_write | (m_read & ~{NUM_M{fifo_full_s}});
    assign fwd_read_s  = sel_read_s & ~fifo_full_s;
    assign accept_s    = (s_write | s_read) & ~s_waitrequest;
    assign fifo_push_s = accept_s & s_read;
    assign fifo_pop_s  = s_readdatavalid & ~fifo_empty_s;

    mm_arb_id_fifo #(
        .WIDTH (GW),
        .DEPTH (MAX_PEND)
    ) u_id_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .din   (grant_q),
        .dout  (head_id_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Pick out the granted master's request fields.
    always_comb begin
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        sel_write_s = 1'b0;
        sel_read_s  = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_q == GW'(i)) begin
                sel_addr_s  = m_address[i*ADDR_W +: ADDR_W];
                sel_wdata_s = m_writedata[i*DATA_W +: DATA_W];
                sel_write_s = m_write[i];
                sel_read_s  = m_read[i];
            end else begin
                sel_addr_s  = sel_addr_s;
            end
        end
    end

    // State register and all other flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= {GW{1'b0}};
            last_grant_q <= GW'(NUM_M - 1);
            orphan_q     <= 1'b0;
            rdv_q        <= {NUM_M{1'b0}};
            rdata_q      <= {(NUM_M*DATA_W){1'b0}};
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            orphan_q     <= orphan_d;
            rdv_q        <= rdv_d;
            rdata_q      <= rdata_d;
        end
    end

    // Next-state: a dropped request releases the grant without advancing priority.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (|req_s) begin
                    state_d = ARB_GRANT;
                    grant_d = rr_pick(req_s, last_grant_q);
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (!(s_write | s_read)) begin
                    state_d = ARB_IDLE;
                end else if (accept_s) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = grant_q;
                end else begin
                    state_d = ARB_GRANT;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Slave-side outputs and per-master stalls.
    always_comb begin
        s_address     = {ADDR_W{1'b0}};
        s_writedata   = {DATA_W{1'b0}};
        s_write       = 1'b0;
        s_read        = 1'b0;
        m_waitrequest = {NUM_M{1'b1}};
        if (state_q == ARB_GRANT) begin
            s_address   = sel_addr_s;
            s_writedata = sel_wdata_s;
            s_write     = sel_write_s;
            s_read      = fwd_read_s;
            for (int i = 0; i < NUM_M; i++) begin
                if (grant_q == GW'(i)) begin
                    m_waitrequest[i] = s_waitrequest | ~(sel_write_s | fwd_read_s);
                end else begin
                    m_waitrequest[i] = 1'b1;
                end
            end
        end else begin
            m_waitrequest = {NUM_M{1'b1}};
        end
    end

    // Response demux onto the lane at the FIFO head; stray responses latch orphan_err.
    always_comb begin
        rdv_d    = {NUM_M{1'b0}};
        rdata_d  = {(NUM_M*DATA_W){1'b0}};
        orphan_d = orphan_q;
        if (fifo_pop_s) begin
            for (int i = 0; i < NUM_M; i++) begin
                if (head_id_s == GW'(i)) begin
                    rdv_d[i]                    = 1'b1;
                    rdata_d[i*DATA_W +: DATA_W] = s_readdata;
                end else begin
                    rdv_d[i] = 1'b0;
                end
            end
        end else if (s_readdatavalid) begin
            orphan_d = 1'b1;
        end else begin
            orphan_d = orphan_q;
        end
    end

    assign m_readdatavalid = rdv_q;
    assign m_readdata      = rdata_q;
    assign orphan_err      = orphan_q;

endmodule

// File: tb/tb_mm_register_arbiter.sv
// Directed bench for mm_register_arbiter: table-driven write/arbitration vectors,
// a latency-programmable slave model with a response scoreboard, and corner-case sequences.
module tb_mm_register_arbiter;
    import mm_register_arbiter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] m_address;
    logic [63:0] m_writedata;
    logic [1:0]  m_write, m_read, m_waitrequest, m_readdatavalid;
    logic [63:0] m_readdata;
    logic [7:0]  s_address;
    logic [31:0] s_writedata, s_readdata;
    logic        s_write, s_read, s_waitrequest, s_readdatavalid, orphan_err;

    logic        slv_rdv, inj_rdv;
    logic [31:0] slv_data, inj_data;
    assign s_readdatavalid = slv_rdv | inj_rdv;
    assign s_readdata      = inj_rdv ? inj_data : slv_data;

    mm_register_arbiter #(.NUM_M(2), .ADDR_W(8), .DATA_W(32), .MAX_PEND(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_address(m_address), .m_writedata(m_writedata),
        .m_write(m_write), .m_read(m_read),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .s_address(s_address), .s_writedata(s_writedata),
        .s_write(s_write), .s_read(s_read), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .orphan_err(orphan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Slave model: responses in order, lat cycles after the accepting cycle.
    typedef struct { int due; logic [31:0] data; bit live; } rsp_t;
    rsp_t        rq[$];
    int          cyc = 0, lat = 2, seq = 0, acc_n = 0;
    int          acc_cyc[16];
    int          acc_own[16];
    bit          slave_en = 1'b0;
    bit          nxt_v = 1'b0, mon_v = 1'b0, mon_en = 1'b0;
    int          nxt_lane = 0, mon_lane = 0;
    logic [31:0] nxt_data = 32'h0, mon_data = 32'h0;

    initial begin
        rsp_t r;
        slv_rdv  = 1'b0;
        slv_data = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            mon_v    = nxt_v;
            mon_lane = nxt_lane;
            mon_data = nxt_data;
            nxt_v    = 1'b0;
            slv_rdv  = 1'b0;
            slv_data = 32'h0;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                r        = rq.pop_front();
                slv_rdv  = 1'b1;
                slv_data = r.data;
                nxt_v    = r.live;
                nxt_lane = int'(r.data[4]);
                nxt_data = r.data;
            end
            #2;
            if (slave_en && rst_n && s_read && !s_waitrequest) begin
                r.due  = cyc + lat;
                r.data = {8'hC0, seq[15:0], s_address};
                r.live = 1'b1;
                rq.push_back(r);
                if (acc_n < 16) begin
                    acc_cyc[acc_n] = cyc;
                    acc_own[acc_n] = int'(s_address[4]);
                end
                acc_n++;
                seq++;
            end
        end
    end

    // Response scoreboard: each live slave response lands on its owner's lane one clock later.
    initial begin
        logic [1:0]  ev;
        logic [63:0] ed;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                ev = 2'b00;
                ed = 64'h0;
                if (mon_v) begin
                    ev = 2'b01 << mon_lane;
                    ed[mon_lane*32 +: 32] = mon_data;
                end
                checks++;
                if (m_readdatavalid !== ev || m_readdata !== ed) begin
                    fails++;
                    $display("FAIL rsp_lane cyc=%0d got v=%b d=%h exp v=%b d=%h",
                             cyc, m_readdatavalid, m_readdata, ev, ed);
                end
            end
        end
    end

    typedef struct {
        logic [1:0]  mw;
        logic        sw;
        logic        e_sw;
        logic        e_sr;
        logic [1:0]  e_mwait;
        logic        chk_a;
        logic [7:0]  e_a;
        logic [31:0] e_d;
    } vec_t;
    vec_t vecs[17];

    task automatic set_vec(input int i, input logic [1:0] mw, input logic sw, input logic e_sw,
                           input logic [1:0] e_mwait, input logic chk_a, input logic [7:0] e_a,
                           input logic [31:0] e_d);
        vecs[i].mw = mw; vecs[i].sw = sw; vecs[i].e_sw = e_sw; vecs[i].e_sr = 1'b0;
        vecs[i].e_mwait = e_mwait; vecs[i].chk_a = chk_a; vecs[i].e_a = e_a; vecs[i].e_d = e_d;
    endtask

    task automatic wait_acc(input int n);
        for (int k = 0; k < 80 && acc_n < n; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && rq.size() > 0; k++) @(negedge clk);
        chk("drain_slave_queue", 64'(rq.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [43:0] got, exp;
        m_address     = {8'h15, SOURCE_MAC_ADDR_2};
        m_writedata   = {32'h12345678, 32'hDEADBEEF};
        m_write       = 2'b00;
        m_read        = 2'b00;
        s_waitrequest = 1'b0;
        inj_rdv       = 1'b0;
        inj_data      = 32'h0;
        rst_n         = 1'b1;

        // Writes, slave stalls, dropped grant and round-robin order.
        set_vec(0,  2'b01, 1'b0, 1'b0, 2'b11, 1'b0, 8'h00, 32'h0);
        set_vec(1,  2'b01, 1'b0, 1'b1, 2'b10, 1'b1, 8'h04, 32'hDEADBEEF);
        set_vec(2,  2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 8'h00, 32'h0);
        set_vec(3,  2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 8'h00, 32'h0);
        set_vec(4,  2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 8'h15, 32'h12345678);
        set_vec(5,  2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 8'h15, 32'h12345678);
        set_vec(6,  2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 8'h15, 32'h12345678);
        set_vec(7,  2'b11, 1'b0, 1'b1, 2'b01, 1'b1, 8'h15, 32'h12345678);
        set_vec(8,  2'b01, 1'b0, 1'b0, 2'b11, 1'b0, 8'h00, 32'h0);
        set_vec(9,  2'b01, 1'b0, 1'b1, 2'b10, 1'b1, 8'h04, 32'hDEADBEEF);
        set_vec(10, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 8'h00, 32'h0);
        set_vec(11, 2'b10, 1'b1, 1'b0, 2'b11, 1'b0, 8'h00, 32'h0);
        set_vec(12, 2'b10, 1'b1, 1'b1, 2'b11, 1'b1, 8'h15, 32'h12345678);
        set_vec(13, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 8'h00, 32'h0);
        set_vec(14, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 8'h00, 32'h0);
        set_vec(15, 2'b11, 1'b0, 1'b1, 2'b01, 1'b1, 8'h15, 32'h12345678);
        set_vec(16, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 8'h00, 32'h0);

        #2 rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_m_waitrequest", 64'(m_waitrequest), 64'h3);
        chk("reset_s_wr_rd", 64'({s_write, s_read}), 64'h0);
        chk("reset_orphan_err", 64'(orphan_err), 64'h0);
        mon_en = 1'b1;

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            m_write       = vecs[i].mw;
            s_waitrequest = vecs[i].sw;
            #1;
            got = {s_write, s_read, m_waitrequest, 8'h00, 32'h0};
            exp = {vecs[i].e_sw, vecs[i].e_sr, vecs[i].e_mwait, 8'h00, 32'h0};
            if (vecs[i].chk_a) begin
                got[39:0] = {s_address, s_writedata};
                exp[39:0] = {vecs[i].e_a, vecs[i].e_d};
            end
            chk($sformatf("vec%0d", i), 64'(got), 64'(exp));
            @(negedge clk);
        end

        // Both masters streaming reads: strict alternation, spaced two cycles apart.
        lat      = 2;
        slave_en = 1'b1;
        acc_n    = 0;
        s_waitrequest = 1'b0;
        m_read   = 2'b11;
        wait_acc(8);
        m_read   = 2'b00;
        chk("t2_accept_count", 64'(acc_n), 64'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("t2_grant%0d", i), 64'(acc_own[i]), 64'(i % 2));
        chk("t2_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd2);
        drain();

        // Five reads against a slow slave: the fifth waits for the first response.
        lat    = 10;
        acc_n  = 0;
        m_read = 2'b01;
        for (int k = 0; k < 80 && acc_n < 5; k++) begin
            @(negedge clk);
            #1;
            if (acc_n == 4 && cyc < acc_cyc[0] + 12)
                chk("t3_stall_wait", 64'(m_waitrequest[0]), 64'h1);
        end
        m_read = 2'b00;
        chk("t3_accept_count", 64'(acc_n), 64'd5);
        chk("t3_fourth_at", 64'(acc_cyc[3] - acc_cyc[0]), 64'd6);
        chk("t3_fifth_at", 64'(acc_cyc[4] - acc_cyc[0]), 64'd12);
        drain();

        // Response with nothing outstanding.
        slave_en = 1'b0;
        @(negedge clk);
        #1;
        chk("t5_orphan_before", 64'(orphan_err), 64'h0);
        @(negedge clk);
        inj_rdv  = 1'b1;
        inj_data = 32'hBAD0BAD0;
        @(negedge clk);
        inj_rdv  = 1'b0;
        #1;
        chk("t5_orphan_set", 64'(orphan_err), 64'h1);
        repeat (3) @(negedge clk);
        #1;
        chk("t5_orphan_sticky", 64'(orphan_err), 64'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_orphan_cleared", 64'(orphan_err), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset with two reads outstanding; their late responses become orphans.
        slave_en = 1'b1;
        lat      = 10;
        acc_n    = 0;
        m_read   = 2'b10;
        wait_acc(2);
        m_read   = 2'b00;
        chk("t6_accept_count", 64'(acc_n), 64'd2);
        @(negedge clk);
        rst_n = 1'b0;
        foreach (rq[i]) rq[i].live = 1'b0;
        #1;
        chk("t6_reset_wait", 64'(m_waitrequest), 64'h3);
        chk("t6_reset_s_read", 64'(s_read), 64'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_write = 2'b11;
        #1;
        chk("t6_idle_wait", 64'(m_waitrequest), 64'h3);
        @(negedge clk);
        #1;
        chk("t6_first_grant", 64'({s_write, m_waitrequest, s_address}), 64'({1'b1, 2'b10, 8'h04}));
        @(negedge clk);
        m_write = 2'b00;
        drain();
        chk("t6_orphan_late", 64'(orphan_err), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
